// File: rtl/mc_pkg.sv
// Shared state encoding, opcodes and ALU-op codes
// for the multicycle controller and its ALU decoder.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECUTE,
    ALUWB,
    BRANCH,
    IMMEXEC,
    IMMWB,
    JUMP
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BLE   = 6'b000110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LI    = 6'b010001;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SUB = 4'b1010;
  localparam logic [3:0] ALU_SLT = 4'b1011;

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps aluop/op/funct to an ALU control code
// and flags an unknown R-type funct.
module aludec
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] alucontrol,
  output logic       funct_bad
);

  always_comb begin
    alucontrol = ALU_ADD;
    funct_bad  = 1'b0;
    if (op == OP_LI) begin
      alucontrol = ALU_LUI;
    end else if (aluop == ALUOP_ADD) begin
      alucontrol = ALU_ADD;
    end else if (aluop == ALUOP_SUB) begin
      alucontrol = ALU_SUB;
    end else begin
      case (funct)
        6'b000000: alucontrol = ALU_SLL;
        6'b100000: alucontrol = ALU_ADD;
        6'b100010: alucontrol = ALU_SUB;
        6'b100100: alucontrol = ALU_AND;
        6'b100101: alucontrol = ALU_OR;
        6'b101010: alucontrol = ALU_SLT;
        6'b110011: alucontrol = ALU_XOR;
        default: begin
          alucontrol = ALU_AND;
          funct_bad  = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle Moore controller: sequences fetch, decode,
// memory, ALU, branch and jump steps for one instruction.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       irwrite,
  output logic       iord,
  output logic       memwrite,
  output logic       sbyte,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic       branch,
  output logic       branchle,
  output logic       illegal_op,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [3:0] alucontrol
);
  import mc_pkg::*;

  state_t     state_q, state_d;
  logic [1:0] aluop;
  logic       funct_bad;

  aludec u_aludec (
    .aluop      (aluop),
    .op         (op),
    .funct      (funct),
    .alucontrol (alucontrol),
    .funct_bad  (funct_bad)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    aluop      = ALUOP_ADD;
    pcwrite    = 1'b0;
    irwrite    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    sbyte      = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    branch     = 1'b0;
    branchle   = 1'b0;
    illegal_op = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    unique case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        pcwrite = mem_ready;
        irwrite = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW, OP_SB: state_d = MEMADR;
          OP_RTYPE:            state_d = EXECUTE;
          OP_BEQ, OP_BLE:      state_d = BRANCH;
          OP_ADDI, OP_LI:      state_d = IMMEXEC;
          OP_J:                state_d = JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = mem_ready;
        sbyte    = (op == OP_SB);
        if (mem_ready) state_d = FETCH;
      end
      EXECUTE: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_FUNCT;
        illegal_op = funct_bad;
        state_d    = ALUWB;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_SUB;
        pcsrc    = 2'b01;
        branch   = (op == OP_BEQ);
        branchle = (op == OP_BLE);
        state_d  = FETCH;
      end
      IMMEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = IMMWB;
      end
      IMMWB: begin
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // architectural write strobes stay quiet while held in reset
    if (!reset) begin
      pcwrite    = 1'b0;
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low; sampled only on rising clk.
REQ-003 SHALL have port: op  input  6  opcode of the instruction register.
REQ-004 SHALL have port: funct  input  6  funct field of the instruction register.
REQ-005 SHALL have port: mem_ready  input  1  memory access completes this cycle.
REQ-006 SHALL have outputs, 1 bit each: pcwrite, irwrite, iord, memwrite, sbyte, regwrite, regdst, memtoreg, alusrca, branch, branchle, illegal_op.
REQ-007 SHALL have outputs alusrcb (2), pcsrc (2) and alucontrol (4).

Function
REQ-008 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, IMMEXEC, IMMWB and JUMP.
REQ-009 SHALL decode opcodes: lw 100011, sw 101011, sb 101000, R-type 000000, beq 000100, ble 000110, addi 001000, li 010001, j 000010.
REQ-010 SHALL hold FETCH until mem_ready=1; in FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, with irwrite=pcwrite=mem_ready.
REQ-011 SHALL leave FETCH for DECODE only on the mem_ready=1 cycle.
REQ-012 SHALL drive alusrca=0, alusrcb=11 and aluop=00 in DECODE (branch target computation).
REQ-013 SHALL transition from DECODE: lw/sw/sb->MEMADR; R-type->EXECUTE; beq/ble->BRANCH; addi/li->IMMEXEC; j->JUMP; any other op->FETCH with illegal_op=1 for that single cycle.
REQ-014 SHALL drive alusrca=1, alusrcb=10 and aluop=00 in MEMADR, then go to MEMRD (lw) or MEMWR (sw, sb).
REQ-015 SHALL drive iord=1 in MEMRD and hold until mem_ready=1, then go to MEMWB.
REQ-016 SHALL drive regdst=0, memtoreg=1 and regwrite=1 in MEMWB, then go to FETCH.
REQ-017 SHALL drive iord=1 and memwrite=mem_ready in MEMWR, with sbyte=1 only for sb; hold until mem_ready=1, then go to FETCH.
REQ-018 SHALL drive alusrca=1, alusrcb=00 and aluop=10 in EXECUTE, then ALUWB; ALUWB drives regdst=1, memtoreg=0 and regwrite=1, then FETCH.
REQ-019 SHALL drive alusrca=1, alusrcb=00, aluop=01 and pcsrc=01 in BRANCH, with branch=1 for beq or branchle=1 for ble (datapath forms pc enable); then FETCH.
REQ-020 SHALL drive alusrca=1, alusrcb=10 and aluop=00 in IMMEXEC, then IMMWB; IMMWB drives regdst=0, memtoreg=0 and regwrite=1, then FETCH.
REQ-021 SHALL drive pcsrc=10 and pcwrite=1 in JUMP, then FETCH.
REQ-022 SHALL drive every output not listed for a state to 0.
REQ-023 SHALL derive alucontrol combinationally from aluop, funct and op: li gives 0110; aluop 00 otherwise gives 0010; aluop 01 gives 1010; R-type funct 000000/100000/100010/100100/100101/101010/110011 give 0100/0010/1010/0000/0001/1011/0101; any other funct gives 0000 with illegal_op=1 in EXECUTE.
REQ-024 SHALL keep its state and outputs unchanged while mem_ready=0 in a waiting state, without limit.

Reset
REQ-025 SHALL load FETCH on any rising clk with reset=0, including mid-instruction, regardless of mem_ready.
REQ-026 SHALL force pcwrite, irwrite, memwrite, regwrite and illegal_op to 0 while reset=0.
REQ-027 SHALL resume at FETCH on the first edge with reset=1; outputs then follow REQ-010.

Structure
REQ-028 SHALL take the state enum, opcode constants and aluop encodings from a shared package, mc_pkg.
REQ-029 SHALL instantiate the existing aludec as its single sub-module to produce alucontrol, fed by an internal 2-bit aluop.

Verification
REQ-030 SHALL cover lw with mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles, regwrite=1 and memtoreg=1 only in cycle 5.
REQ-031 SHALL cover R-type funct 101010 -> 4 cycles, alucontrol=1011 in EXECUTE, regwrite=1 and regdst=1 in ALUWB.
REQ-032 SHALL cover FETCH with mem_ready low for 3 cycles -> irwrite=pcwrite=0 for 3 cycles, both 1 on cycle 4, then DECODE.
REQ-033 SHALL cover sb with mem_ready=1 -> memwrite=1 and sbyte=1 for exactly one cycle in MEMWR; ble -> branchle=1 and aluop=01.
REQ-034 SHALL cover reset=0 asserted in MEMRD -> FETCH next edge, no regwrite pulse; op 111111 -> illegal_op pulse, back to FETCH.
